// File: rtl/pb_classify.sv
// pb_classify: synchronizes and debounces a push-button, then classifies presses.
// Define PB_DOUBLE_CLICK_EN to add the GAP state and double-click detection.
module pb_classify #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 1000,
    parameter int GAP_CYCLES      = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic double_click
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 2);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || GAP_CYCLES < 2) begin : g_bad_params
        $error("pb_classify: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        WAIT_REL,
        GAP
    } state_t;

    logic            sync1;
    logic            pb_s;
    logic            pb_db;
    logic            pb_db_nxt;
    logic            pb_prev;
    logic [DB_W-1:0] db_cnt;

    // The count must already sit at DB_MAX when one more differing sample
    // arrives, giving a fixed 2+DEBOUNCE_CYCLES latency from the pin.
    always_comb begin
        pb_db_nxt = pb_db;
        if (pb_s != pb_db && db_cnt == DB_MAX)
            pb_db_nxt = pb_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            pb_s    <= 1'b1;
            pb_db   <= 1'b1;
            pb_prev <= 1'b1;
            db_cnt  <= '0;
            pressed <= 1'b0;
        end else begin
            sync1   <= PB;
            pb_s    <= sync1;
            pb_db   <= pb_db_nxt;
            pb_prev <= pb_db;
            pressed <= ~pb_db_nxt;
            if (pb_s == pb_db || db_cnt == DB_MAX)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + DB_W'(1);
        end
    end

    logic press_ev;
    logic rel_ev;

    assign press_ev = pb_prev & ~pb_db;
    assign rel_ev   = ~pb_prev & pb_db;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;

`ifdef PB_DOUBLE_CLICK_EN
    localparam int GAP_W = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);

    logic [GAP_W-1:0] gap_cnt;
`else
    assign double_click = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
`ifdef PB_DOUBLE_CLICK_EN
            gap_cnt      <= '0;
            double_click <= 1'b0;
`endif
        end else begin
            short_press <= 1'b0;
            long_press  <= 1'b0;
`ifdef PB_DOUBLE_CLICK_EN
            double_click <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (press_ev) begin
                        state    <= HELD;
                        hold_cnt <= '0;
                    end
                end
                HELD: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        long_press <= 1'b1;
                        state      <= WAIT_REL;
                        hold_cnt   <= '0;
                    end else if (rel_ev) begin
                        hold_cnt <= '0;
`ifdef PB_DOUBLE_CLICK_EN
                        state    <= GAP;
                        gap_cnt  <= '0;
`else
                        short_press <= 1'b1;
                        state       <= IDLE;
`endif
                    end
                end
                WAIT_REL: begin
                    if (pb_db) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                end
`ifdef PB_DOUBLE_CLICK_EN
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                    if (press_ev) begin
                        double_click <= 1'b1;
                        state        <= WAIT_REL;
                        gap_cnt      <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                        gap_cnt     <= '0;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pb_classify.sv
// tb_pb_classify: vector table, hand sequences and random stimulus against
// a time-stamp based reference model of the push-button classifier.
module tb_pb_classify;

    localparam int D = 4;
    localparam int L = 20;
    localparam int G = 10;

`ifdef PB_DOUBLE_CLICK_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic PB = 1'b1;
    logic pressed;
    logic short_press;
    logic long_press;
    logic double_click;

    pb_classify #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PB(PB),
        .pressed(pressed),
        .short_press(short_press),
        .long_press(long_press),
        .double_click(double_click)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: sampled-pin history plus press/release timestamps
    bit hist[$];
    bit m_db;
    bit m_db1;
    int mode;
    int t_ref;
    bit e_pr, e_sh, e_lg, e_dc;

    int n_sh, n_lg, n_dc, n_pchg;
    int c_pr, c_pf, c_sh, c_lg, c_dc;
    bit prev_pressed = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 3; i++) hist.push_back(1'b1);
        m_db = 1'b1;
        m_db1 = 1'b1;
        mode = 0;
        t_ref = 0;
        e_pr = 0; e_sh = 0; e_lg = 0; e_dc = 0;
    endtask

    // one clock edge: classify from last two debounced levels, then debounce
    task automatic model_edge(input bit pb);
        bit prs, rel, all;
        int n;
        e_sh = 0; e_lg = 0; e_dc = 0;
        prs = m_db1 & ~m_db;
        rel = ~m_db1 & m_db;
        case (mode)
            0: if (prs) begin mode = 1; t_ref = cyc; end
            1: begin
                if (cyc - t_ref == L - 1) begin
                    e_lg = 1; mode = 2;
                end else if (rel) begin
                    if (DC) begin mode = 3; t_ref = cyc; end
                    else begin e_sh = 1; mode = 0; end
                end
            end
            2: if (m_db) mode = 0;
            default: begin
                if (prs) begin e_dc = 1; mode = 2; end
                else if (cyc - t_ref == G - 1) begin e_sh = 1; mode = 0; end
            end
        endcase
        hist.push_back(pb);
        if (hist.size() > 64) void'(hist.pop_front());
        n = hist.size();
        all = 1;
        for (int j = 0; j <= D; j++)
            if (hist[n-3-j] == m_db) all = 0;
        m_db1 = m_db;
        if (all) m_db = ~m_db;
        e_pr = ~m_db;
    endtask

    task automatic clr_mon();
        n_sh = 0; n_lg = 0; n_dc = 0; n_pchg = 0;
        c_pr = -1; c_pf = -1; c_sh = -1; c_lg = -1; c_dc = -1;
    endtask

    task automatic step(input bit pb, input bit rn = 1'b1);
        PB = pb;
        rst_n = rn;
        @(posedge clk);
        cyc++;
        if (!rn) model_reset();
        else model_edge(pb);
        #1;
        chk("pressed", pressed, e_pr);
        chk("short_press", short_press, e_sh);
        chk("long_press", long_press, e_lg);
        chk("double_click", double_click, e_dc);
        if (pressed !== prev_pressed) begin
            n_pchg++;
            if (pressed) c_pr = cyc;
            else c_pf = cyc;
        end
        prev_pressed = pressed;
        if (short_press) begin n_sh++; c_sh = cyc; end
        if (long_press) begin n_lg++; c_lg = cyc; end
        if (double_click) begin n_dc++; c_dc = cyc; end
    endtask

    task automatic hold(input bit pb, input int n);
        for (int i = 0; i < n; i++) step(pb);
    endtask

    typedef struct {
        string nm;
        int    low1;
        int    high;
        int    low2;
        int    e_short;
        int    e_long;
        int    e_dbl;
    } vec_t;

    vec_t vt[$];

    initial begin
        int fc, rc;
        bit lvl;
        model_reset();
        clr_mon();

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_pressed", pressed, 0);
        chk("rst_pulses", {short_press, long_press, double_click}, 0);
        hold(1'b1, 10);

        vt.push_back('{"short10", 10, 0, 0, 1, 0, 0});
        vt.push_back('{"long40", 40, 0, 0, 0, 1, 0});
        vt.push_back('{"glitch4", 4, 0, 0, 0, 0, 0});
        vt.push_back('{"min5", 5, 0, 0, 1, 0, 0});
        vt.push_back('{"short18", 18, 0, 0, 1, 0, 0});
        vt.push_back('{"long19", 19, 0, 0, 0, 1, 0});
        vt.push_back('{"bounce4", 10, 4, 10, 0, 1, 0});
        vt.push_back('{"dbl_gap6", 10, 6, 10, DC ? 0 : 2, 0, DC ? 1 : 0});
        vt.push_back('{"dbl_gap9", 10, 9, 10, DC ? 0 : 2, 0, DC ? 1 : 0});
        vt.push_back('{"two_gap10", 10, 10, 10, 2, 0, 0});

        foreach (vt[k]) begin
            hold(1'b1, 20);
            clr_mon();
            hold(1'b0, vt[k].low1);
            hold(1'b1, vt[k].high);
            hold(1'b0, vt[k].low2);
            hold(1'b1, 45);
            chk({vt[k].nm, "_short"}, n_sh, vt[k].e_short);
            chk({vt[k].nm, "_long"}, n_lg, vt[k].e_long);
            chk({vt[k].nm, "_dbl"}, n_dc, vt[k].e_dbl);
        end

        // short press latency
        clr_mon();
        fc = cyc + 1;
        hold(1'b0, 10);
        hold(1'b1, 30);
        chk("press_latency", c_pr - fc, 6);
        chk("short_latency", c_sh - c_pf, DC ? 10 : 1);
        chk("short_once", n_sh, 1);
        chk("short_no_other", n_lg + n_dc, 0);

        // long press latency, nothing at release
        clr_mon();
        hold(1'b0, 40);
        hold(1'b1, 40);
        chk("long_latency", c_lg - c_pr, 20);
        chk("long_once", n_lg, 1);
        chk("long_no_other", n_sh + n_dc, 0);

        // bounce every 2 clocks never settles
        clr_mon();
        for (int i = 0; i < 30; i++) step(((i / 2) % 2) != 0);
        hold(1'b1, 20);
        chk("toggle_pressed", n_pchg, 0);
        chk("toggle_pulses", n_sh + n_lg + n_dc, 0);

        // reset while held at hold_cnt=15
        clr_mon();
        for (int i = 0; i < 20 && !pressed; i++) step(1'b0);
        chk("rst_seq_pressed", pressed, 1);
        hold(1'b0, 16);
        step(1'b0, 1'b0);
        chk("rst_mid_pressed", pressed, 0);
        rc = cyc + 1;
        hold(1'b0, 10);
        chk("rst_repress_latency", c_pr - rc, 6);
        chk("rst_no_long", n_lg, 0);
        hold(1'b1, 40);

        // random segments, with one reset in the middle
        lvl = 1'b0;
        for (int s = 0; s < 60; s++) begin
            if (s == 30) step(lvl, 1'b0);
            hold(lvl, int'($urandom_range(1, 28)));
            lvl = ~lvl;
        end
        hold(1'b1, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pb_classify.md
PB_CLASSIFY -- requirements
Module: pb_classify

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a PB level change; legal range 1 and up.
REQ-002 Parameter LONG_CYCLES, default 1000: debounced hold length that qualifies as a long press; legal range 2 and up.
REQ-003 Parameter GAP_CYCLES, default 250: maximum debounced release-to-press gap that qualifies as a double click; legal range 2 and up.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous and active-low; sampled only on posedge clk.
REQ-006 PB  input  1  raw asynchronous push-button; pulled up, so 1 = idle and 0 = pressed.
REQ-007 pressed  output  1  debounced level; 1 while the button is held.
REQ-008 short_press  output  1  single-cycle pulse for a qualified short press.
REQ-009 long_press  output  1  single-cycle pulse when a hold reaches LONG_CYCLES.
REQ-010 double_click  output  1  single-cycle pulse on the second press of a double click.

Function
REQ-011 PB SHALL pass through a 2-flop synchronizer, producing pb_s; both flops reset to 1.
REQ-012 Debounce: pb_db SHALL take the value of pb_s once pb_s has differed from pb_db for DEBOUNCE_CYCLES consecutive cycles; any cycle with pb_s equal to pb_db clears the count.
REQ-013 With PB held stable, the pb_db change SHALL occur exactly 2+DEBOUNCE_CYCLES clocks after the first edge at which PB is sampled at its new level.
REQ-014 Output pressed SHALL equal ~pb_db (registered, no added latency). A press event is a 1->0 transition of pb_db; a release event is a 0->1 transition.
REQ-015 FSM states SHALL be IDLE, HELD, WAIT_REL and GAP.
REQ-016 IDLE: a press event SHALL move to HELD and clear hold_cnt.
REQ-017 HELD: hold_cnt SHALL increment each cycle. When hold_cnt reaches LONG_CYCLES-1, long_press SHALL pulse and the FSM SHALL move to WAIT_REL. This takes priority over a release event in the same cycle.
REQ-018 HELD: a release event before that threshold SHALL move to GAP and clear gap_cnt (only when PB_DOUBLE_CLICK_EN is defined; see REQ-026 and REQ-027).
REQ-019 GAP: gap_cnt SHALL increment each cycle. A press event SHALL pulse double_click and move to WAIT_REL. Otherwise, when gap_cnt reaches GAP_CYCLES-1, short_press SHALL pulse and the FSM SHALL move to IDLE. A press event wins if both occur in the same cycle.
REQ-020 WAIT_REL: the FSM SHALL move to IDLE on the first cycle in which pb_db==1 (level-sensitive), with no pulse.
REQ-021 Counters SHALL be sized $clog2 of their parameter and SHALL never wrap; each is cleared on every state entry.
REQ-022 At most one of short_press, long_press and double_click SHALL be high in any cycle; each pulse SHALL be exactly one cycle wide.

Reset
REQ-023 While rst_n==0 at a posedge, the synchronizer flops and pb_db SHALL load 1, all counters SHALL load 0 and the FSM SHALL load IDLE.
REQ-024 While rst_n==0 at a posedge, pressed, short_press, long_press and double_click SHALL load 0.
REQ-025 Reset asserted mid-operation SHALL abandon any pending classification with no pulse; after release, a button still held SHALL re-debounce as a fresh press.

Configuration
REQ-026 With macro PB_DOUBLE_CLICK_EN defined: the GAP state, gap_cnt and double_click detection SHALL be present as in REQ-018 and REQ-019.
REQ-027 With PB_DOUBLE_CLICK_EN undefined: a release event in HELD SHALL pulse short_press on that same cycle's register update and move to IDLE. GAP logic SHALL be absent, and double_click SHALL be tied to 0.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, GAP_CYCLES=10)
REQ-028 PB low for 10 clocks, then high and idle -> pressed rises 6 clocks after the PB fall; with the macro defined, short_press pulses once 10 clocks after pressed falls; no other pulse.
REQ-029 PB low for 40 clocks -> long_press pulses once, 20 clocks after pressed rises; no pulse at release.
REQ-030 Two 10-clock presses separated by 6 clocks of PB high (macro defined) -> exactly one double_click at the second debounced press; no short_press.
REQ-031 PB toggling every 2 clocks for 30 clocks -> pressed never changes; no pulses.
REQ-032 rst_n=0 for 1 clock while in HELD at hold_cnt=15, PB still low -> no long_press; pressed=0 after reset, then re-rises 6 clocks later.
REQ-033 Macro undefined, PB low for 10 clocks -> short_press pulses on the cycle after pressed falls; double_click stays 0 throughout.
